// File: rtl/motor_pkg.sv
// motor_pkg: definitions shared between the hall decoder and the commutation controller.
//   sector_t       : 3-bit sector index, 0..5 valid, SECTOR_INVALID (7) otherwise
//   HallFwdOrder   : hall codes {hall1,hall2,hall3} in forward (positive PWM) order
//   hall_to_sector : maps a hall code to its sector, SECTOR_INVALID for 000/111
//   sector_fwd/rev : modulo-6 neighbours of a valid sector
package motor_pkg;

  typedef logic [2:0] sector_t;

  localparam int NumSectors = 6;
  localparam sector_t SECTOR_INVALID = 3'd7;

  // Index i holds the hall code of sector i; the commutation tables use the same table.
  localparam logic [2:0] HallFwdOrder [NumSectors] = '{
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001
  };

  function automatic sector_t hall_to_sector(input logic [2:0] code);
    sector_t s;
    s = SECTOR_INVALID;
    for (int i = 0; i < NumSectors; i++) begin
      if (code == HallFwdOrder[i]) s = sector_t'(i);
    end
    return s;
  endfunction

  function automatic sector_t sector_fwd(input sector_t s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic sector_t sector_rev(input sector_t s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

endpackage

// File: rtl/hall_position_decoder_if.sv
// hall_position_decoder_if: hall inputs, control requests and decoded outputs.
//   slave  : the decoder (consumes hall/requests, drives position/velocity/status)
//   master : the environment driving the raw hall lines and requests
interface hall_position_decoder_if;

  logic               hall1;
  logic               hall2;
  logic               hall3;
  logic               position_zero;
  logic               error_clear;
  logic signed [31:0] position;
  logic signed [31:0] velocity;
  logic               vel_valid;
  logic               step;
  logic               direction;
  logic               hall_error;

  modport master (
    output hall1, hall2, hall3, position_zero, error_clear,
    input  position, velocity, vel_valid, step, direction, hall_error
  );

  modport slave (
    input  hall1, hall2, hall3, position_zero, error_clear,
    output position, velocity, vel_valid, step, direction, hall_error
  );

endinterface

// File: rtl/hall_debounce.sv
// hall_debounce: 2-flop synchronizer and debounce counter for the 3-bit hall bus.
//   CLK, reset : clock, synchronous active-high reset
//   raw        : asynchronous hall lines {hall1,hall2,hall3}
//   code       : current debounce candidate
//   accept     : high for the one cycle in which code is accepted (combinational,
//                so the consumer registers its update on the accepting edge)
module hall_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [2:0] raw,
  output logic [2:0] code,
  output logic       accept
);

  localparam logic [15:0] CntMax = 16'(DEBOUNCE_CYCLES - 1);

  logic [2:0]  sync1_q;
  logic [2:0]  sync2_q;
  logic [2:0]  cand_q;
  logic [2:0]  accepted_q;
  logic [15:0] cnt_q;

  // accepted_q resets to the same value as cand_q so nothing is accepted spuriously.
  always_comb begin
    code   = cand_q;
    accept = (cnt_q == CntMax) && (cand_q != accepted_q);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      cand_q     <= 3'b000;
      accepted_q <= 3'b000;
      cnt_q      <= 16'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= 16'd0;
      end else if (cnt_q < CntMax) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (accept) accepted_q <= cand_q;
    end
  end

endmodule

// File: rtl/hall_position_decoder.sv
// hall_position_decoder: BLDC hall sensors -> signed step position, windowed velocity and
// sticky sequence-error flag.
//   CLK, reset : clock, synchronous active-high reset
//   bus        : hall1..3, position_zero, error_clear in; position, velocity, vel_valid,
//                step, direction, hall_error out (all outputs registered)
module hall_position_decoder
  import motor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned VEL_WINDOW      = 1_000_000
) (
  input logic                    CLK,
  input logic                    reset,
  hall_position_decoder_if.slave bus
);

  localparam logic [31:0] WinLast = 32'(VEL_WINDOW - 1);

  logic [2:0] raw;
  logic [2:0] code;
  logic       accept;

  sector_t            sector_q, sector_d, new_sector;
  logic signed [31:0] position_q, position_d;
  logic signed [31:0] velocity_q;
  logic signed [31:0] vel_acc_q, vel_sum;
  logic signed [31:0] step_delta;
  logic [31:0]        win_cnt_q;
  logic               vel_valid_q, step_q, direction_q, hall_error_q, hall_error_d;
  logic               fwd, rev, bad, win_end;

  assign raw = {bus.hall1, bus.hall2, bus.hall3};

  hall_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK   (CLK),
    .reset (reset),
    .raw   (raw),
    .code  (code),
    .accept(accept)
  );

  assign new_sector = hall_to_sector(code);

  always_comb begin
    fwd      = 1'b0;
    rev      = 1'b0;
    bad      = 1'b0;
    sector_d = sector_q;
    if (accept) begin
      if (new_sector == SECTOR_INVALID) begin
        bad = 1'b1;
      end else if (sector_q == SECTOR_INVALID) begin
        sector_d = new_sector;
      end else if (new_sector == sector_q) begin
        // Back to the same sector after an invalid code: no motion, no new error.
        sector_d = new_sector;
      end else if (new_sector == sector_fwd(sector_q)) begin
        fwd      = 1'b1;
        sector_d = new_sector;
      end else if (new_sector == sector_rev(sector_q)) begin
        rev      = 1'b1;
        sector_d = new_sector;
      end else begin
        bad      = 1'b1;
        sector_d = new_sector;
      end
    end

    step_delta = fwd ? 32'sd1 : (rev ? -32'sd1 : 32'sd0);
    // Zero is applied before the step so a coincident step survives the clear.
    position_d = (bus.position_zero ? 32'sd0 : position_q) + step_delta;
    // A new error wins over a simultaneous clear.
    hall_error_d = bad ? 1'b1 : (bus.error_clear ? 1'b0 : hall_error_q);

    win_end = (win_cnt_q == WinLast);
    vel_sum = vel_acc_q + step_delta;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sector_q     <= SECTOR_INVALID;
      position_q   <= 32'sd0;
      velocity_q   <= 32'sd0;
      vel_acc_q    <= 32'sd0;
      win_cnt_q    <= 32'd0;
      vel_valid_q  <= 1'b0;
      step_q       <= 1'b0;
      direction_q  <= 1'b0;
      hall_error_q <= 1'b0;
    end else begin
      sector_q     <= sector_d;
      position_q   <= position_d;
      step_q       <= fwd | rev;
      hall_error_q <= hall_error_d;
      if (fwd) begin
        direction_q <= 1'b1;
      end else if (rev) begin
        direction_q <= 1'b0;
      end
      if (win_end) begin
        win_cnt_q   <= 32'd0;
        velocity_q  <= vel_sum;
        vel_acc_q   <= 32'sd0;
        vel_valid_q <= 1'b1;
      end else begin
        win_cnt_q   <= win_cnt_q + 32'd1;
        vel_acc_q   <= vel_sum;
        vel_valid_q <= 1'b0;
      end
    end
  end

  assign bus.position   = position_q;
  assign bus.velocity   = velocity_q;
  assign bus.vel_valid  = vel_valid_q;
  assign bus.step       = step_q;
  assign bus.direction  = direction_q;
  assign bus.hall_error = hall_error_q;

endmodule

// File: tb/tb_hall_position_decoder.sv
// tb_hall_position_decoder: directed vectors with hand-computed expectations for
// hall_position_decoder (DEBOUNCE_CYCLES=4, VEL_WINDOW=100).
module tb_hall_position_decoder;

  localparam int unsigned Debounce  = 4;
  localparam int unsigned VelWindow = 100;

  localparam logic [2:0] FwdSeq [7] = '{
    3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101
  };

  logic CLK = 1'b0;
  logic reset = 1'b1;

  hall_position_decoder_if bus ();

  hall_position_decoder #(
    .DEBOUNCE_CYCLES(Debounce),
    .VEL_WINDOW     (VelWindow)
  ) dut (
    .CLK  (CLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Edge index since reset release: 0 on the first rising edge that samples reset low.
  int win_edge = 0;
  always @(posedge CLK) win_edge <= reset ? -1 : win_edge + 1;

  // Record vel_valid pulses (edge index and value) since the last reset.
  int                 vv_n = 0;
  int                 vv_edge [4];
  logic signed [31:0] vv_val  [4];
  always @(negedge CLK) begin
    if (reset) begin
      vv_n <= 0;
    end else if (bus.vel_valid) begin
      if (vv_n < 4) begin
        vv_edge[vv_n] <= win_edge;
        vv_val[vv_n]  <= bus.velocity;
      end
      vv_n <= vv_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_hall(input logic [2:0] c);
    bus.hall1 = c[2];
    bus.hall2 = c[1];
    bus.hall3 = c[0];
  endtask

  // Called on a falling edge: applies code c, then waits hold falling edges. zero_at/clr_at
  // give the edge index (0 = first rising edge after the change) at which the request is
  // sampled; -1 disables. Reports step pulses seen and the edge index of the last one.
  task automatic drive_code(input logic [2:0] c, input int hold, input int zero_at,
                            input int clr_at, output int nsteps, output int step_edge);
    set_hall(c);
    nsteps    = 0;
    step_edge = -1;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      if (bus.step) begin
        nsteps++;
        step_edge = i;
      end
      bus.position_zero = (i == zero_at - 1);
      bus.error_clear   = (i == clr_at - 1);
    end
    bus.position_zero = 1'b0;
    bus.error_clear   = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge CLK);
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_position"}, bus.position, 32'h0);
    check({tag, "_velocity"}, bus.velocity, 32'h0);
    check({tag, "_vel_valid"}, 32'(bus.vel_valid), 32'h0);
    check({tag, "_step"}, 32'(bus.step), 32'h0);
    check({tag, "_direction"}, 32'(bus.direction), 32'h0);
    check({tag, "_hall_error"}, 32'(bus.hall_error), 32'h0);
  endtask

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (win_edge < target && guard < 400) begin
      @(negedge CLK);
      guard++;
    end
    check("wait_edge_timeout", 32'(guard >= 400), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ns, se;
    set_hall(3'b000);
    bus.position_zero = 1'b0;
    bus.error_clear   = 1'b0;
    @(negedge CLK);
    do_reset(3);
    check_zero("reset");

    // Forward rotation: first code only loads the sector, then six +1 steps at edge 6.
    for (int i = 0; i < 7; i++) begin
      drive_code(FwdSeq[i], 20, -1, -1, ns, se);
      check("fwd_nsteps", 32'(ns), (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) check("fwd_step_edge", 32'(se), 32'd6);
    end
    check("fwd_position", bus.position, 32'd6);
    check("fwd_direction", 32'(bus.direction), 32'd1);
    check("fwd_hall_error", 32'(bus.hall_error), 32'd0);

    // Reverse with a 3-cycle glitch in between.
    do_reset(2);
    drive_code(3'b101, 20, -1, -1, ns, se);
    check("rev_init_nsteps", 32'(ns), 32'd0);
    drive_code(3'b100, 3, -1, -1, ns, se);
    drive_code(3'b001, 20, -1, -1, ns, se);
    check("rev_nsteps", 32'(ns), 32'd1);
    check("rev_position", bus.position, 32'hFFFF_FFFF);
    check("rev_direction", 32'(bus.direction), 32'd0);
    check("rev_hall_error", 32'(bus.hall_error), 32'd0);

    // Errors: invalid code, lone clear, illegal jump, clear colliding with a new error.
    drive_code(3'b111, 20, -1, -1, ns, se);
    check("err111_flag", 32'(bus.hall_error), 32'd1);
    check("err111_position", bus.position, 32'hFFFF_FFFF);
    drive_code(3'b111, 3, -1, 1, ns, se);
    check("clear_lone_1", 32'(bus.hall_error), 32'd0);
    drive_code(3'b101, 20, -1, -1, ns, se);
    check("recover_position", bus.position, 32'd0);
    drive_code(3'b010, 20, -1, -1, ns, se);
    check("jump_flag", 32'(bus.hall_error), 32'd1);
    check("jump_position", bus.position, 32'd0);
    check("jump_nsteps", 32'(ns), 32'd0);
    drive_code(3'b010, 3, -1, 1, ns, se);
    check("clear_lone_2", 32'(bus.hall_error), 32'd0);
    drive_code(3'b000, 20, -1, 6, ns, se);
    check("clear_vs_error", 32'(bus.hall_error), 32'd1);
    drive_code(3'b000, 3, -1, 1, ns, se);
    check("clear_lone_3", 32'(bus.hall_error), 32'd0);

    // Velocity: steps at edges 21,34,47,60,73,86,99 then reverse at 119,139,159.
    do_reset(2);
    drive_code(3'b101, 15, -1, -1, ns, se);
    for (int i = 1; i < 7; i++) drive_code(FwdSeq[i], 13, -1, -1, ns, se);
    drive_code(3'b100, 20, -1, -1, ns, se);
    drive_code(3'b101, 20, -1, -1, ns, se);
    drive_code(3'b001, 20, -1, -1, ns, se);
    drive_code(3'b011, 20, -1, -1, ns, se);
    wait_edge(205);
    check("vel_pulses", 32'(vv_n), 32'd2);
    check("vel0_edge", 32'(vv_edge[0]), 32'd99);
    check("vel0_value", vv_val[0], 32'd7);
    check("vel1_edge", 32'(vv_edge[1]), 32'd199);
    check("vel1_value", vv_val[1], 32'hFFFF_FFFD);
    check("vel_position", bus.position, 32'd4);

    // Signed wrap from a forced 0x7FFFFFFF start.
    do_reset(2);
    drive_code(3'b101, 20, -1, -1, ns, se);
    force dut.position_q = 32'sh7FFF_FFFF;
    @(negedge CLK);
    release dut.position_q;
    @(negedge CLK);
    drive_code(3'b100, 20, -1, -1, ns, se);
    check("wrap_nsteps", 32'(ns), 32'd1);
    check("wrap_position", bus.position, 32'h8000_0000);

    // position_zero sampled on the same edge as a forward step.
    drive_code(3'b110, 20, 6, -1, ns, se);
    check("zero_step_nsteps", 32'(ns), 32'd1);
    check("zero_step_position", bus.position, 32'd1);
    wait_edge(102);
    check("win2_velocity", bus.velocity, 32'd2);
    check("win2_direction", 32'(bus.direction), 32'd1);

    // Reset mid-window with the error flag set.
    drive_code(3'b111, 20, -1, -1, ns, se);
    check("pre_reset_error", 32'(bus.hall_error), 32'd1);
    reset = 1'b1;
    @(negedge CLK);
    check_zero("mid_reset");
    reset = 1'b0;
    drive_code(3'b011, 20, -1, -1, ns, se);
    check("reinit_nsteps", 32'(ns), 32'd0);
    check("reinit_position", bus.position, 32'd0);
    drive_code(3'b001, 20, -1, -1, ns, se);
    check("post_reinit_nsteps", 32'(ns), 32'd1);
    check("post_reinit_position", bus.position, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hall_position_decoder.md
# hall_position_decoder

Decodes the three raw hall-sensor inputs of a BLDC motor into a signed 32-bit commutation-step position, a windowed velocity and sequence-error status. Sits directly upstream of the motor PID/commutation controller: `position` drives its `state` input, so the loop closes on hall ticks. The hall sector order is the same one the commutation tables use for positive PWM, so positive PWM yields increasing `position`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles before a hall code is accepted; legal range 2..65535.
- `VEL_WINDOW`, default 1_000_000: velocity sample period in CLK cycles; legal range ≥2.
- `CLK`  in  1: sole clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `hall1`, `hall2`, `hall3`  in  1 each: raw, asynchronous hall inputs.
- `position_zero`  in  1: one-cycle request to clear `position`.
- `error_clear`  in  1: one-cycle request to clear `hall_error`.
- `position`  out  32 signed: accumulated step count.
- `velocity`  out  32 signed: net steps counted in the last complete window.
- `vel_valid`  out  1: one-cycle pulse when `velocity` updates.
- `step`  out  1: one-cycle pulse on each accepted legal step.
- `direction`  out  1: 1 = last legal step forward, 0 = reverse.
- `hall_error`  out  1: sticky flag for an illegal code or an illegal transition.

## Operation
- Reset values: `position` 0, `velocity` 0, `vel_valid` 0, `step` 0, `direction` 0, `hall_error` 0. Sector is marked invalid. Debounce and window counters are cleared.
- Sync stage: 2-flop synchronizer per hall line, giving sync code {hall1,hall2,hall3}.
- Debounce stage:
  - If sync code ≠ candidate: candidate <= sync code, count <= 0.
  - Else if count < DEBOUNCE_CYCLES-1: count increments.
  - When count == DEBOUNCE_CYCLES-1 and candidate ≠ accepted code, the candidate is accepted; this happens once per change.
- Sector map (forward order): 101→0, 100→1, 110→2, 010→3, 011→4, 001→5. Codes 000 and 111 are invalid.
- Handling an accepted code:
  - Invalid code: `hall_error` <= 1; sector and position are unchanged.
  - Sector currently invalid (first code after reset): load sector; no step.
  - New = (old+1) mod 6: `position` +1, `direction` <= 1, `step` pulse.
  - New = (old+5) mod 6: `position` −1, `direction` <= 0, `step` pulse.
  - Any other delta (2, 3 or 4): `hall_error` <= 1; load sector; no position change.
- Position arithmetic is 32-bit two's complement and wraps silently: 0x7FFFFFFF +1 → 0x80000000.
- Velocity:
  - Window counter runs 0..VEL_WINDOW-1.
  - A 32-bit accumulator adds ±1 per step.
  - At count VEL_WINDOW-1: `velocity` <= accumulator plus the current cycle's step delta; accumulator <= 0; `vel_valid` pulses.
- Simultaneous events:
  - `position_zero` with a step: `position` <= step delta (±1). Zero is applied first, then the step.
  - `error_clear` with a new error: `hall_error` stays 1.
  - Window end with a step: the step is counted in the emitted `velocity`.
- Reset mid-operation overrides every input in that cycle. The next accepted valid code re-initializes the sector without producing a step.

## Timing
- Edge 0 is the first rising edge that samples a new stable hall code.
- Accept, `step`, `position` and `direction` update all register at edge DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES cycles (after sync) is never accepted.
- `step` and `vel_valid` are exactly one cycle wide and are registered outputs.
- `vel_valid` period is exactly VEL_WINDOW cycles; the first pulse comes at edge VEL_WINDOW-1 after reset deasserts.
- `position_zero` / `error_clear` take effect on the edge that samples them; outputs change 1 cycle later.

## Structure
- Shared package `motor_pkg` holds:
  - sector constants and the `SECTOR_INVALID` encoding (3-bit, value 7);
  - function `hall_to_sector(code)`;
  - the forward code order, shared with the commutation controller so both use one definition.
- Sub-module `hall_debounce` covers the 2-flop sync plus debounce counter for the 3-bit bus. Ports: CLK, reset, raw[2:0] → code[2:0], accept pulse. Parameter: DEBOUNCE_CYCLES.
- Top level holds the sector tracker, position counter, error flag and velocity window.

## Test plan
- Forward rotation: DEBOUNCE_CYCLES=4; hold each code 20 cycles through 101,100,110,010,011,001,101. Required: first code gives no step; then 6 steps, `position`=6, `direction`=1, each `step` at edge 6 after the change.
- Reverse plus glitch: after 101, apply a 3-cycle 100 pulse, then 001 held. Required: glitch ignored; `position`=−1, `direction`=0, `hall_error`=0.
- Errors: apply 111, then jump from 101 to 010. Required: `hall_error`=1 with `position` unchanged. `error_clear` while 000 is being accepted keeps the flag at 1; a lone `error_clear` clears it.
- Velocity: VEL_WINDOW=100; 7 forward steps in the first window, with a step landing on cycle 99. Required: `velocity`=7 with a `vel_valid` pulse at cycle 99; the next window with 3 reverse steps gives `velocity`=−3.
- Boundaries:
  - Preload 0x7FFFFFFF via steps (forced start), then 1 forward step. Required: 0x80000000.
  - `position_zero` coincident with a forward step. Required: `position`=1.
  - Reset asserted mid-window. Required: all outputs return to 0 the next cycle.
